// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver that packs MEMORY_LENGTH bytes
// into one word and pulses dataReady when the word is complete.
module uart_rx_buffer #(
  parameter int DELAY_FRAMES  = 8,
  parameter int MEMORY_LENGTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  output logic [MEMORY_LENGTH*8-1:0] data,
  output logic                       dataReady,
  output logic                       frame_error,
  output logic                       busy
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int BW = (MEMORY_LENGTH > 1) ? $clog2(MEMORY_LENGTH) : 1;
  localparam int WW = MEMORY_LENGTH * 8;

  localparam logic [CW-1:0] HALF_LAST = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(MEMORY_LENGTH - 1);
  localparam logic [BW-1:0] BYTE_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;

  // Two-flop synchronizer; idles high so reset does not fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: half-bit align on start, then full-bit sampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    word_d  = word_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            word_d[{byte_q, 3'b000} +: 8] = shift_q;
            if (byte_q == BYTE_LAST) begin
              data_d = word_d;
              rdy_d  = 1'b1;
              byte_d = '0;
            end else begin
              byte_d = byte_q + BYTE_ONE;
            end
          end else begin
            ferr_d  = 1'b1;
            byte_d  = '0;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data        = data_q;
  assign dataReady   = rdy_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: scoreboard bench for uart_rx_buffer,
// default parameters (8 clocks/bit, 2-byte words).
module tb_uart_rx_buffer;

  localparam int DF = 8;

  logic        clk;
  logic        rst_n;
  logic        uart_rx;
  logic [15:0] data;
  logic        dataReady;
  logic        frame_error;
  logic        busy;

  uart_rx_buffer #(
    .DELAY_FRAMES (DF),
    .MEMORY_LENGTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .data       (data),
    .dataReady  (dataReady),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rdy = 0;
  int          n_ferr = 0;
  int          exp_rdy = 0;
  int          exp_ferr = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mb0;
  int          midx = 0;
  logic [15:0] last_word = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (DF) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_ok) begin
      if (midx == 0) begin
        mb0  = b;
        midx = 1;
      end else begin
        last_word = {b, mb0};
        exp_q.push_back(last_word);
        exp_rdy++;
        midx = 0;
      end
    end else begin
      midx = 0;
      exp_ferr++;
    end
    drive_bit(stop_ok);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data", data, 0);
    chk("rst_rdy", dataReady, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_busy", busy, 0);
    uart_rx = 1'b1;
    midx = 0;
    last_word = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dataReady) begin
        n_rdy++;
        if (exp_q.size() == 0) begin
          chk("ready_unexp", 1, 0);
        end else begin
          logic [15:0] w;
          w = exp_q.pop_front();
          chk("word", data, w);
        end
      end
      if (frame_error) n_ferr++;
      if (dataReady || frame_error)
        chk("rdy_ferr_excl", dataReady & frame_error, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    do_reset();

    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    idle(20);
    chk("single_data", data, 16'hA355);
    chk("single_ferr", n_ferr, exp_ferr);

    do_reset();
    send_byte(8'h12, 1'b1);
    idle(200);
    chk("partial_rdy", n_rdy, exp_rdy);
    chk("partial_data", data, last_word);
    send_byte(8'h34, 1'b1);
    idle(20);
    chk("partial_done", data, 16'h3412);

    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < DF / 2 + 3; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    chk("fs_busy_seen", seen, 1);
    chk("fs_busy_low", busy, 0);
    idle(20);
    chk("fs_rdy", n_rdy, exp_rdy);
    chk("fs_ferr", n_ferr, exp_ferr);

    send_byte(8'h7E, 1'b0);
    uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    idle(20);
    chk("fe_count", n_ferr, exp_ferr);
    chk("fe_hold", data, last_word);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(20);
    chk("fe_after", data, 16'h0201);
    chk("fe_count2", n_ferr, exp_ferr);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(20);
    chk("rst_mid_data", data, 16'h00FF);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(40);
    chk("b2b_data", data, 16'h4433);

    chk("end_queue", exp_q.size(), 0);
    chk("end_rdy", n_rdy, exp_rdy);
    chk("end_ferr", n_ferr, exp_ferr);
    chk("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
